fetch_stage: RTL and testbench

Instruction fetch stage of the dual-issue VLIW pipeline: holds the PC, fetches one 32-bit bundle per cycle from instruction memory over a single-outstanding request/valid handshake, and drives the IF/ID (p1) pipeline register consumed by the decode stage. It splits each bundle into the ALU-slot and MEM-slot 16-bit instructions. It also absorbs decode stalls with a one-entry hold buffer and applies branch/jump redirects from execute, flushing wrong-path bundles.

---
 rtl/fetch_stage.sv | 146 ++++++++++++++
 tb/tb_fetch_stage.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, single-outstanding imem handshake, IF/ID (p1) register,
// one-entry hold buffer for decode stalls and redirect/flush handling.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p1_pipeline_regWrite,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [15:0] p1_aluInstr,
  output logic [15:0] p1_memInstr,
  output logic [31:0] p1_pc,
  output logic        p1_valid
);

  typedef enum logic [1:0] {StFetch, StHold, StDrain} state_e;

  localparam logic [31:0] AlignMask = 32'hFFFF_FFFC;

  state_e      r_state, w_state_d;
  logic [31:0] r_pc, w_pc_d;
  logic [31:0] r_p1_instr, w_p1_instr_d;
  logic [31:0] r_p1_pc, w_p1_pc_d;
  logic        r_p1_valid, w_p1_valid_d;
  logic [31:0] r_hold_instr, w_hold_instr_d;
  logic [31:0] r_hold_pc, w_hold_pc_d;
  logic [31:0] r_pend, w_pend_d;

  logic        w_can_accept;
  logic [31:0] w_target;

  assign w_can_accept = p1_pipeline_regWrite | ~r_p1_valid;
  assign w_target     = redirect_target & AlignMask;

  // Request is a function of FSM state only; held low while reset is asserted.
  assign imem_req    = reset & (r_state != StHold);
  assign imem_addr   = r_pc;
  assign p1_aluInstr = r_p1_instr[15:0];
  assign p1_memInstr = r_p1_instr[31:16];
  assign p1_pc       = r_p1_pc;
  assign p1_valid    = r_p1_valid;

  // Next-state and datapath updates for the fetch FSM.
  always_comb begin
    w_state_d      = r_state;
    w_pc_d         = r_pc;
    w_p1_instr_d   = r_p1_instr;
    w_p1_pc_d      = r_p1_pc;
    w_p1_valid_d   = r_p1_valid;
    w_hold_instr_d = r_hold_instr;
    w_hold_pc_d    = r_hold_pc;
    w_pend_d       = r_pend;

    // Flush dominates stall in every state.
    if (redirect_valid) begin
      w_p1_valid_d = 1'b0;
    end

    unique case (r_state)
      StFetch: begin
        if (redirect_valid) begin
          if (imem_rvalid) begin
            // Wrong-path data discarded; request already complete.
            w_pc_d = w_target;
          end else begin
            // Outstanding request must complete at the old address first.
            w_pend_d  = w_target;
            w_state_d = StDrain;
          end
        end else if (imem_rvalid) begin
          w_pc_d = r_pc + 32'd4;
          if (w_can_accept) begin
            w_p1_instr_d = imem_rdata;
            w_p1_pc_d    = r_pc;
            w_p1_valid_d = 1'b1;
          end else begin
            w_hold_instr_d = imem_rdata;
            w_hold_pc_d    = r_pc;
            w_state_d      = StHold;
          end
        end else if (p1_pipeline_regWrite) begin
          w_p1_valid_d = 1'b0;
        end
      end
      StHold: begin
        if (redirect_valid) begin
          w_pc_d    = w_target;
          w_state_d = StFetch;
        end else if (p1_pipeline_regWrite) begin
          w_p1_instr_d = r_hold_instr;
          w_p1_pc_d    = r_hold_pc;
          w_p1_valid_d = 1'b1;
          w_state_d    = StFetch;
        end
      end
      StDrain: begin
        if (imem_rvalid) begin
          // A redirect arriving with the completion wins over the older target.
          w_pc_d    = redirect_valid ? w_target : r_pend;
          w_state_d = StFetch;
        end else if (redirect_valid) begin
          w_pend_d = w_target;
        end
      end
      default: begin
        w_state_d = StFetch;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= StFetch;
    end else begin
      r_state <= w_state_d;
    end
  end

  // PC, p1 pipeline register, hold buffer and pending redirect target.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc         <= RESET_PC & AlignMask;
      r_p1_instr   <= 32'd0;
      r_p1_pc      <= 32'd0;
      r_p1_valid   <= 1'b0;
      r_hold_instr <= 32'd0;
      r_hold_pc    <= 32'd0;
      r_pend       <= 32'd0;
    end else begin
      r_pc         <= w_pc_d;
      r_p1_instr   <= w_p1_instr_d;
      r_p1_pc      <= w_p1_pc_d;
      r_p1_valid   <= w_p1_valid_d;
      r_hold_instr <= w_hold_instr_d;
      r_hold_pc    <= w_hold_pc_d;
      r_pend       <= w_pend_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: one task per scenario, inline comparisons.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        regwrite;
  logic        redir;
  logic [31:0] redir_tgt;
  logic        zw;       // zero-wait memory: rvalid follows imem_req
  logic        rv_man;   // manual rvalid when zw=0

  logic        req0, req1, rv0, rv1, val0, val1;
  logic [31:0] addr0, addr1, rd0, rd1, pc0, pc1;
  logic [15:0] alu0, alu1, mem0, mem1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Memory returns address-tagged bundles.
  assign rv0 = zw ? req0 : rv_man;
  assign rv1 = zw ? req1 : rv_man;
  assign rd0 = {addr0[15:0] ^ 16'hBEEF, addr0[15:0]};
  assign rd1 = {addr1[15:0] ^ 16'hBEEF, addr1[15:0]};

  fetch_stage dut0 (
    .clk(clk), .reset(reset), .p1_pipeline_regWrite(regwrite),
    .redirect_valid(redir), .redirect_target(redir_tgt),
    .imem_req(req0), .imem_addr(addr0), .imem_rvalid(rv0), .imem_rdata(rd0),
    .p1_aluInstr(alu0), .p1_memInstr(mem0), .p1_pc(pc0), .p1_valid(val0)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut1 (
    .clk(clk), .reset(reset), .p1_pipeline_regWrite(regwrite),
    .redirect_valid(redir), .redirect_target(redir_tgt),
    .imem_req(req1), .imem_addr(addr1), .imem_rvalid(rv1), .imem_rdata(rd1),
    .p1_aluInstr(alu1), .p1_memInstr(mem1), .p1_pc(pc1), .p1_valid(val1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step();
    reset = 1'b0; regwrite = 1'b1; redir = 1'b0; redir_tgt = 32'd0;
    zw = 1'b1; rv_man = 1'b0;
    step();
    step();
    reset = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    step();
    reset = 1'b0; regwrite = 1'b1; redir = 1'b0; redir_tgt = 32'd0;
    zw = 1'b1; rv_man = 1'b0;
    #1;
    n_cmp++;
    if ({req0, val0, pc0, alu0, mem0} !== {1'b0, 1'b0, 32'd0, 16'd0, 16'd0}) begin
      n_err++;
      $display("FAIL reset_state: req=%b valid=%b pc=%h alu=%h mem=%h, need 0,0,0,0,0",
               req0, val0, pc0, alu0, mem0);
    end
    step();
    reset = 1'b1;
    #1;
    n_cmp++;
    if (req0 !== 1'b1 || addr0 !== 32'd0) begin
      n_err++;
      $display("FAIL reset_release: req=%b addr=%h, need 1 and 00000000", req0, addr0);
    end
  endtask

  task automatic test_stream();
    logic [31:0] e;
    for (int k = 1; k <= 6; k++) begin
      step();
      e = 32'(4 * (k - 1));
      n_cmp++;
      if (val0 !== 1'b1 || pc0 !== e || alu0 !== e[15:0] || mem0 !== (e[15:0] ^ 16'hBEEF)
          || addr0 !== e + 32'd4) begin
        n_err++;
        $display("FAIL stream_%0d: valid=%b pc=%h alu=%h mem=%h addr=%h, need 1 %h %h %h %h",
                 k, val0, pc0, alu0, mem0, addr0, e, e[15:0], e[15:0] ^ 16'hBEEF, e + 32'd4);
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    step(); step(); step();
    regwrite = 1'b0;  // p1 holds bundle 8, bundle 12 being fetched
    for (int k = 0; k < 3; k++) begin
      step();
      n_cmp++;
      if (val0 !== 1'b1 || pc0 !== 32'd8 || req0 !== 1'b0) begin
        n_err++;
        $display("FAIL stall_%0d: valid=%b pc=%h req=%b, need 1 00000008 0", k, val0, pc0, req0);
      end
    end
    regwrite = 1'b1;
    step();
    n_cmp++;
    if (val0 !== 1'b1 || pc0 !== 32'd12 || alu0 !== 16'd12 || req0 !== 1'b1
        || addr0 !== 32'd16) begin
      n_err++;
      $display("FAIL stall_release: valid=%b pc=%h alu=%h req=%b addr=%h, need 1 c c 1 10",
               val0, pc0, alu0, req0, addr0);
    end
    step();
    n_cmp++;
    if (val0 !== 1'b1 || pc0 !== 32'd16 || addr0 !== 32'd20) begin
      n_err++;
      $display("FAIL stall_resume: valid=%b pc=%h addr=%h, need 1 10 14", val0, pc0, addr0);
    end
  endtask

  task automatic test_redirect_hit();
    // imem_addr is 20 with rvalid=1; redirect with junk low bits
    redir = 1'b1; redir_tgt = 32'h0000_0103;
    step();
    redir = 1'b0;
    n_cmp++;
    if (val0 !== 1'b0 || addr0 !== 32'h100 || pc0 !== 32'd16) begin
      n_err++;
      $display("FAIL redirect_hit: valid=%b addr=%h pc=%h, need 0 100 10", val0, addr0, pc0);
    end
    step();
    n_cmp++;
    if (val0 !== 1'b1 || pc0 !== 32'h100 || alu0 !== 16'h100 || addr0 !== 32'h104) begin
      n_err++;
      $display("FAIL redirect_target: valid=%b pc=%h alu=%h addr=%h, need 1 100 100 104",
               val0, pc0, alu0, addr0);
    end
  endtask

  task automatic test_drain();
    do_reset();
    zw = 1'b0; rv_man = 1'b0;
    redir = 1'b1; redir_tgt = 32'h40;
    step();
    redir = 1'b0;
    n_cmp++;
    if (req0 !== 1'b1 || addr0 !== 32'd0 || val0 !== 1'b0) begin
      n_err++;
      $display("FAIL drain_wait1: req=%b addr=%h valid=%b, need 1 0 0", req0, addr0, val0);
    end
    step();
    n_cmp++;
    if (req0 !== 1'b1 || addr0 !== 32'd0) begin
      n_err++;
      $display("FAIL drain_wait2: req=%b addr=%h, need 1 0", req0, addr0);
    end
    rv_man = 1'b1;
    step();
    rv_man = 1'b0;
    n_cmp++;
    if (val0 !== 1'b0 || addr0 !== 32'h40 || req0 !== 1'b1) begin
      n_err++;
      $display("FAIL drain_done: valid=%b addr=%h req=%b, need 0 40 1", val0, addr0, req0);
    end
    rv_man = 1'b1;
    step();
    rv_man = 1'b0;
    n_cmp++;
    if (val0 !== 1'b1 || pc0 !== 32'h40 || alu0 !== 16'h40) begin
      n_err++;
      $display("FAIL drain_fetch: valid=%b pc=%h alu=%h, need 1 40 40", val0, pc0, alu0);
    end
  endtask

  task automatic test_redirect_hold();
    do_reset();
    step();              // p1 = bundle 0
    regwrite = 1'b0;
    step();              // bundle 4 buffered, HOLD
    n_cmp++;
    if (req0 !== 1'b0 || pc0 !== 32'd0 || val0 !== 1'b1) begin
      n_err++;
      $display("FAIL hold_enter: req=%b pc=%h valid=%b, need 0 0 1", req0, pc0, val0);
    end
    redir = 1'b1; redir_tgt = 32'h200;
    step();
    redir = 1'b0;
    n_cmp++;
    if (val0 !== 1'b0 || req0 !== 1'b1 || addr0 !== 32'h200) begin
      n_err++;
      $display("FAIL hold_redirect: valid=%b req=%b addr=%h, need 0 1 200", val0, req0, addr0);
    end
    step();              // p1 empty so it accepts despite stall
    n_cmp++;
    if (val0 !== 1'b1 || pc0 !== 32'h200 || alu0 !== 16'h200) begin
      n_err++;
      $display("FAIL hold_target: valid=%b pc=%h alu=%h, need 1 200 200", val0, pc0, alu0);
    end
    regwrite = 1'b1;
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc [4];
    exp_pc[0] = 32'hFFFF_FFF8; exp_pc[1] = 32'hFFFF_FFFC; exp_pc[2] = 32'd0; exp_pc[3] = 32'd4;
    do_reset();
    n_cmp++;
    if (req1 !== 1'b1 || addr1 !== 32'hFFFF_FFF8) begin
      n_err++;
      $display("FAIL wrap_start: req=%b addr=%h, need 1 fffffff8", req1, addr1);
    end
    for (int k = 0; k < 4; k++) begin
      step();
      n_cmp++;
      if (val1 !== 1'b1 || pc1 !== exp_pc[k]) begin
        n_err++;
        $display("FAIL wrap_%0d: valid=%b pc=%h, need 1 %h", k, val1, pc1, exp_pc[k]);
      end
    end
    zw = 1'b0; rv_man = 1'b0;
    step();              // request to 0x8 outstanding
    reset = 1'b0;
    #1;
    n_cmp++;
    if (req1 !== 1'b0 || val1 !== 1'b0 || pc1 !== 32'd0) begin
      n_err++;
      $display("FAIL wrap_midreset: req=%b valid=%b pc=%h, need 0 0 0", req1, val1, pc1);
    end
    step();
    reset = 1'b1;
    #1;
    n_cmp++;
    if (req1 !== 1'b1 || addr1 !== 32'hFFFF_FFF8) begin
      n_err++;
      $display("FAIL wrap_restart: req=%b addr=%h, need 1 fffffff8", req1, addr1);
    end
  endtask

  initial begin
    reset = 1'b0; regwrite = 1'b1; redir = 1'b0; redir_tgt = 32'd0; zw = 1'b1; rv_man = 1'b0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect_hit();
    test_drain();
    test_redirect_hold();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
